// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
package pipeline_ctrl_pkg;

  localparam int unsigned STATE_W = 2;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned HAZ_W   = 2;

  localparam logic [HAZ_W-1:0] HAZ_REQ  = 2'b01;
  localparam logic [HAZ_W-1:0] HAZ_NONE = 2'b00;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN          = 2'd0,
    ST_LOAD_STALL   = 2'd1,
    ST_BRANCH_FLUSH = 2'd2
  } ctrl_state_e;

  // Per-stage enable/clear strobes driven to the datapath.
  typedef struct packed {
    logic pc_enable;
    logic if_id_enable;
    logic id_ex_enable;
    logic ex_mem_enable;
    logic mem_wb_enable;
    logic if_id_clear;
    logic id_ex_clear;
  } stage_ctrl_t;

  localparam stage_ctrl_t STAGE_RUN = '{
    pc_enable: 1'b1, if_id_enable: 1'b1, id_ex_enable: 1'b1,
    ex_mem_enable: 1'b1, mem_wb_enable: 1'b1,
    if_id_clear: 1'b0, id_ex_clear: 1'b0
  };

  localparam stage_ctrl_t STAGE_FREEZE = '0;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear+inc yields 1.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Next count: clear wins, then saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? W'(1) : '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Turns hazard, branch and memory-busy requests into per-stage enable/clear
// strobes, sequencing multi-cycle bubbles and branch squash windows.
module pipeline_stall_controller
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned LOAD_BUBBLES   = 1,
  parameter int unsigned BRANCH_PENALTY = 2,
  parameter int unsigned STAT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [HAZ_W-1:0]  nop,
  input  logic [HAZ_W-1:0]  flush,
  input  logic              branch_taken_execute,
  input  logic              mem_busy,
  input  logic              clear_stats,
  output logic              pc_enable,
  output logic              if_id_enable,
  output logic              id_ex_enable,
  output logic              ex_mem_enable,
  output logic              mem_wb_enable,
  output logic              if_id_clear,
  output logic              id_ex_clear,
  output logic [STATE_W-1:0] state_o,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_events
);

  localparam logic [CNT_W-1:0] BUBBLE_RELOAD = CNT_W'(LOAD_BUBBLES - 1);
  localparam logic [CNT_W-1:0] SQUASH_RELOAD = CNT_W'(BRANCH_PENALTY - 1);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  stage_ctrl_t      ctrl;
  logic             stall_inc;
  logic             flush_inc;

  // Next-state and same-cycle strobe decode; priority busy > branch > nop > flush.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl      = STAGE_RUN;
    stall_inc = 1'b0;
    flush_inc = 1'b0;

    if (rst_n) begin
      if (mem_busy) begin
        ctrl      = STAGE_FREEZE;
        stall_inc = 1'b1;
      end else begin
        case (state_q)
          ST_RUN, ST_LOAD_STALL: begin
            if (branch_taken_execute) begin
              ctrl.if_id_clear = 1'b1;
              ctrl.id_ex_clear = 1'b1;
              flush_inc        = 1'b1;
              if (BRANCH_PENALTY > 1) begin
                state_d = ST_BRANCH_FLUSH;
                cnt_d   = SQUASH_RELOAD;
              end else begin
                state_d = ST_RUN;
                cnt_d   = '0;
              end
            end else if ((state_q == ST_LOAD_STALL) || (nop == HAZ_REQ)) begin
              ctrl.pc_enable    = 1'b0;
              ctrl.if_id_enable = 1'b0;
              ctrl.id_ex_clear  = 1'b1;
              stall_inc         = 1'b1;
              if (state_q == ST_LOAD_STALL) begin
                if (cnt_q <= CNT_W'(1)) begin
                  state_d = ST_RUN;
                  cnt_d   = '0;
                end else begin
                  cnt_d = cnt_q - CNT_W'(1);
                end
              end else if (LOAD_BUBBLES > 1) begin
                state_d = ST_LOAD_STALL;
                cnt_d   = BUBBLE_RELOAD;
              end
            end else if (flush == HAZ_REQ) begin
              ctrl.if_id_clear = 1'b1;
            end
          end
          ST_BRANCH_FLUSH: begin
            ctrl.if_id_clear = 1'b1;
            ctrl.id_ex_clear = 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
          default: begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        endcase
      end
    end
  end

  // State and sequence counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  sat_counter #(.W(STAT_W)) u_stall_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (stall_inc),
    .clr     (clear_stats),
    .count_o (stall_cycles)
  );

  sat_counter #(.W(STAT_W)) u_flush_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (flush_inc),
    .clr     (clear_stats),
    .count_o (flush_events)
  );

  assign pc_enable     = ctrl.pc_enable;
  assign if_id_enable  = ctrl.if_id_enable;
  assign id_ex_enable  = ctrl.id_ex_enable;
  assign ex_mem_enable = ctrl.ex_mem_enable;
  assign mem_wb_enable = ctrl.mem_wb_enable;
  assign if_id_clear   = ctrl.if_id_clear;
  assign id_ex_clear   = ctrl.id_ex_clear;
  assign state_o       = STATE_W'(state_q);

endmodule
